// File: rtl/fp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_pkg: shared binary32 constants and field struct                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package fp_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int EXP_MAX = 254;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_mul_core: combinational binary32 multiply (FTZ, truncation)    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fp_mul_core
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        ex
);

    localparam logic signed [9:0] BIAS_S = 10'(FP_BIAS);
    localparam logic signed [9:0] MAX_S  = 10'(EXP_MAX);

    fp32_t             op_a;
    fp32_t             op_b;
    fp32_t             res;
    logic [23:0]       sig_a;
    logic [23:0]       sig_b;
    logic [47:0]       prod;
    logic              norm;
    logic signed [9:0] exp_sum;
    logic              any_zero;
    logic              unused_bits;

    assign op_a  = fp32_t'(a);
    assign op_b  = fp32_t'(b);
    assign sig_a = {1'b1, op_a.frac};
    assign sig_b = {1'b1, op_b.frac};
    assign prod  = sig_a * sig_b;
    assign norm  = prod[47];

    // Operand exponents are zero-extended into a signed 10-bit range so
    // that both overflow (up to 384) and underflow (down to -125) are visible.
    assign exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                   - BIAS_S + $signed({9'b0, norm});

    assign any_zero = (op_a.exp == '0) || (op_b.exp == '0);

    // Truncated low-order product bits are intentionally discarded.
    assign unused_bits = ^prod[22:0];

    always_comb begin
        res      = '0;
        ex       = 1'b0;
        if (any_zero) begin
            res = '0;
            ex  = 1'b0;
        end else if ((exp_sum > MAX_S) || (exp_sum < 10'sd1)) begin
            res = '0;
            ex  = 1'b1;
        end else begin
            res.sign = op_a.sign ^ op_b.sign;
            res.exp  = exp_sum[7:0];
            res.frac = norm ? prod[46:24] : prod[45:23];
        end
    end

    assign p = res;

endmodule
`default_nettype wire

// File: rtl/fp_mul.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_mul: binary32 multiplier with registered product and flag      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fp_mul
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] M1,
    input  logic [31:0] M2,
    output logic [31:0] P,
    output logic        EX
);

    logic [31:0] core_p;
    logic        core_ex;

    fp_mul_core u_core (
        .a  (M1),
        .b  (M2),
        .p  (core_p),
        .ex (core_ex)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            P  <= '0;
            EX <= 1'b0;
        end else begin
            P  <= core_p;
            EX <= core_ex;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp_mul: directed self-checking bench for fp_mul                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_fp_mul;

    logic        clk;
    logic        rst;
    logic [31:0] M1;
    logic [31:0] M2;
    logic [31:0] P;
    logic        EX;

    int tests;
    int fails;

    fp_mul dut (
        .clk (clk),
        .rst (rst),
        .M1  (M1),
        .M2  (M2),
        .P   (P),
        .EX  (EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_p, input logic exp_ex);
        tests++;
        assert ((P === exp_p) && (EX === exp_ex))
        else begin
            fails++;
            $error("FAIL %s: P=%h EX=%b, expected P=%h EX=%b", tag, P, EX, exp_p, exp_ex);
        end
    endtask

    // Drive operands away from the active edge, clock once, sample 1 ns later.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic exp_ex);
        @(negedge clk);
        M1 = a;
        M2 = b;
        @(posedge clk);
        #1;
        check(tag, exp_p, exp_ex);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        M1    = 32'h4580_0000;
        M2    = 32'h4580_0000;
        @(posedge clk);
        #1;
        check("reset", 32'h0000_0000, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        step("4096sq",     32'h4580_0000, 32'h4580_0000, 32'h4B80_0000, 1'b0);
        step("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step("neg_x_zero", 32'hC152_6666, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step("denorm",     32'h0080_0000, 32'h0018_0000, 32'h0000_0000, 1'b0);
        step("1p5sq",      32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
        step("3x_neg2",    32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 1'b0);
        step("overflow",   32'h7F80_0000, 32'h7F80_0000, 32'h0000_0000, 1'b1);
        step("underflow",  32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1);
        step("trunc_lsb",  32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
        step("trunc_max",  32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0);
        step("zero_over",  32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step("neg_x_neg",  32'hC040_0000, 32'hC000_0000, 32'h40C0_0000, 1'b0);

        // Output must hold between edges even though operands change.
        @(negedge clk);
        M1 = 32'h3FC0_0000;
        M2 = 32'h3FC0_0000;
        #1;
        check("hold", 32'h40C0_0000, 1'b0);

        // Mid-stream reset with live operands, then release.
        rst = 1'b1;
        M1  = 32'h4040_0000;
        M2  = 32'h4040_0000;
        @(posedge clk);
        #1;
        check("mid_reset", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", 32'h4110_0000, 1'b0);

        step("b2b_1", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
        step("b2b_2", 32'h7F00_0000, 32'h7F00_0000, 32'h0000_0000, 1'b1);
        step("b2b_3", 32'h4000_0000, 32'hBF80_0000, 32'hC000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
